// File: rtl/mem_ls_pkg.sv
// Shared types and sizing helpers for the load/store memory controller.
package mem_ls_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to count 0..timeout-1; never below one bit.
  function automatic int tmr_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int TMR_W = tmr_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bounded wait counter: counts enabled cycles up to TIMEOUT-1 and holds there.
module mem_timeout_ctr
  import mem_ls_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = tmr_width(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_reg;

  assign expired = (count_reg == LAST);

  // Clear has priority; counting stops at the last value so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_load_store_ctrl.sv
// Load/store controller: one CPU access at a time to a req/ack external memory,
// with a bounded wait and a held load-result register feeding write-back.
module mem_load_store_ctrl
  import mem_ls_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] mem_data,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  state_t state_reg;
  logic   tmr_expired;

  // Timer runs only while waiting for an ack; it restarts from zero in IDLE.
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg == IDLE),
    .enable  ((state_reg == WAIT) && !ext_ack),
    .expired (tmr_expired)
  );

  // Access sequencing with all outputs registered; ack beats timeout on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_data  <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (cpu_req) begin
            ext_req   <= 1'b1;
            ext_we    <= cpu_we;
            ext_addr  <= cpu_addr;
            ext_wdata <= cpu_wdata;
            busy      <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (ext_ack) begin
            if (!ext_we) mem_data <= ext_rdata;
            ext_req   <= 1'b0;
            done      <= 1'b1;
            state_reg <= RESP;
          end else if (tmr_expired) begin
            if (!ext_we) mem_data <= ERR_DATA;
            ext_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ext_req   <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_store_ctrl.sv
// Randomized bench for mem_load_store_ctrl against a transaction-level model.
module tb_mem_load_store_ctrl;

  localparam int TIMEOUT = 16;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        busy, done, err;
  logic [15:0] mem_data;
  logic        ext_req, ext_we;
  logic [7:0]  ext_addr;
  logic [15:0] ext_wdata, ext_rdata;
  logic        ext_ack;

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;
  logic [15:0] model_mem_data;

  always #5 clk = ~clk;

  mem_load_store_ctrl #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(ERR_DATA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_data (mem_data),
    .ext_req  (ext_req),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata),
    .ext_ack  (ext_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One access starting from an IDLE negedge. d = index of the WAIT cycle
  // carrying ext_ack (d >= TIMEOUT means no ack at all).
  task automatic do_txn(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input int d, input logic [15:0] rdata);
    int exp_off;
    logic exp_err;
    int c;
    bit got;
    exp_off = (d < TIMEOUT) ? d + 2 : TIMEOUT + 1;
    exp_err = (d >= TIMEOUT);
    if (!we) model_mem_data = exp_err ? ERR_DATA : rdata;

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    ext_ack = 1'($urandom_range(0, 1)); ext_rdata = 16'($urandom);
    step();
    c = 1;
    got = 0;
    while (!got && c <= TIMEOUT + 3) begin
      if (done) begin
        got = 1;
      end else begin
        chk("wait_ext_req", ext_req, 1);
        chk("wait_busy", busy, 1);
        chk("wait_ext_we", ext_we, we);
        chk("wait_ext_addr", ext_addr, addr);
        chk("wait_ext_wdata", ext_wdata, wdata);
        cpu_req = 1'($urandom_range(0, 1));
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom);
        cpu_wdata = 16'($urandom);
        ext_ack = (c - 1 == d);
        ext_rdata = (c - 1 == d) ? rdata : 16'($urandom);
        step();
        c++;
      end
    end
    chk("done_latency", c, exp_off);
    chk("resp_done", done, 1);
    chk("resp_err", err, exp_err);
    chk("resp_busy", busy, 1);
    chk("resp_ext_req", ext_req, 0);
    chk("resp_mem_data", mem_data, model_mem_data);
    // Stretched/late ack and a stray request during RESP must be ignored.
    cpu_req = 1'($urandom_range(0, 1));
    ext_ack = 1'($urandom_range(0, 1));
    ext_rdata = 16'($urandom);
    step();
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ext_req", ext_req, 0);
    chk("idle_mem_data", mem_data, model_mem_data);
    $display("txn %0d we=%0d addr=%02h wdata=%04h ack_at=%0d done_at=N+%0d err=%0d mem_data=%04h",
             n_txn, we, addr, wdata, d, c, err, mem_data);
    n_txn++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_req = 1'b0;
      ext_ack = 1'($urandom_range(0, 1));
      ext_rdata = 16'($urandom);
      step();
      chk("gap_busy", busy, 0);
      chk("gap_ext_req", ext_req, 0);
      chk("gap_mem_data", mem_data, model_mem_data);
    end
  endtask

  // Abort an access in WAIT with an asynchronous reset, then ignore a stretched ack.
  task automatic reset_mid_wait();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h5A; cpu_wdata = 16'h1234;
    ext_ack = 1'b0;
    step();
    cpu_req = 1'b0;
    step();
    step();
    chk("pre_rst_ext_req", ext_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_mem_data = '0;
    chk("rst_ext_req", ext_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_data", mem_data, model_mem_data);
    ext_ack = 1'b1; ext_rdata = 16'hBEEF;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ext_req", ext_req, 0);
      chk("post_rst_mem_data", mem_data, model_mem_data);
    end
    ext_ack = 1'b0;
    $display("txn %0d reset mid-WAIT, stretched ack ignored, mem_data=%04h", n_txn, mem_data);
    n_txn++;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_ack = 1'b0; ext_rdata = '0;
    model_mem_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_ext_req", ext_req, 0);
    chk("reset_ext_we", ext_we, 0);
    chk("reset_ext_addr", ext_addr, 0);
    chk("reset_ext_wdata", ext_wdata, 0);
    chk("reset_mem_data", mem_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: fast load, slow store, load timeout, ack on final timer cycle.
    do_txn(1'b0, 8'h20, 16'h0000, 0, 16'h7780);
    do_txn(1'b1, 8'h44, 16'hAA44, 5, 16'h5555);
    chk("store_keeps_mem_data", mem_data, 16'h7780);
    do_txn(1'b0, 8'h10, 16'h0000, TIMEOUT, 16'h0000);
    chk("timeout_mem_data", mem_data, 16'hFFFF);
    do_txn(1'b0, 8'h11, 16'h0000, TIMEOUT - 1, 16'h3C3C);
    do_txn(1'b1, 8'h12, 16'h9999, TIMEOUT + 2, 16'h0000);
    // Back-to-back with cpu_req held high into the next IDLE cycle.
    do_txn(1'b0, 8'h13, 16'h0000, 1, 16'h0F0F);
    do_txn(1'b0, 8'h14, 16'h0000, 0, 16'hF0F0);

    for (int i = 0; i < 40; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = TIMEOUT - 1 + int'($urandom_range(0, 2));
        default: d = int'($urandom_range(0, TIMEOUT + 1));
      endcase
      do_txn(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), d, 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
    end

    idle_cycles(1);
    reset_mid_wait();
    do_txn(1'b0, 8'h77, 16'h0000, 2, 16'hC0DE);
    do_txn(1'b1, 8'h78, 16'h4321, 0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
